// File: rtl/ram_responder.sv
// Data-RAM endpoint driven by a four-phase trigger handshake, one word access per handshake.
// Optional RAM_ZERO_INIT_EN: every reset sweeps the array to zero before requests are accepted.
module ram_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataIn,
  input  logic [31:0] addrIn,
  input  logic        rwIn,
  input  logic        triggerIn,
  output logic [31:0] dataOut,
  output logic        readyOut,
  output logic        errOut
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, CLEAR} state_t;

  state_t                 state;
  logic                   sync1;
  logic                   sync2;
  logic [3:0]             cnt;
  logic [31:0]            addr_reg;
  logic [31:0]            data_reg;
  logic                   rw_reg;
  logic [31:0]            mem [DEPTH];
  logic [ADDR_BITS-1:0]   index;
  logic                   err;
  logic                   complete;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [31:0]            mem_wdata;

  assign index    = addr_reg[ADDR_BITS+1:2];
  assign err      = (addr_reg[1:0] != 2'b00) || ((addr_reg >> (ADDR_BITS + 2)) != 32'd0);
  assign complete = (state == BUSY) && (cnt == 4'd0);

`ifdef RAM_ZERO_INIT_EN
  localparam state_t RESET_STATE = CLEAR;
  logic [ADDR_BITS-1:0] clr_idx;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = index;
    mem_wdata = data_reg;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = 32'd0;
      end else if (complete && rw_reg && !err) begin
        mem_we = 1'b1;
      end
    end
  end
`else
  localparam state_t RESET_STATE = IDLE;

  always_comb begin
    mem_we    = !reset && complete && rw_reg && !err;
    mem_waddr = index;
    mem_wdata = data_reg;
  end
`endif

  // Write port kept free of reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      state    <= RESET_STATE;
      cnt      <= 4'd0;
      readyOut <= 1'b0;
      dataOut  <= 32'd0;
      errOut   <= 1'b0;
      addr_reg <= 32'd0;
      data_reg <= 32'd0;
      rw_reg   <= 1'b0;
`ifdef RAM_ZERO_INIT_EN
      clr_idx  <= '0;
`endif
    end else begin
      sync1 <= triggerIn;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          if (sync2) begin
            addr_reg <= addrIn;
            data_reg <= dataIn;
            rw_reg   <= rwIn;
            cnt      <= CNT_INIT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            readyOut <= 1'b1;
            errOut   <= err;
            if (err) begin
              dataOut <= 32'd0;
            end else if (rw_reg) begin
              dataOut <= data_reg;
            end else begin
              dataOut <= mem[index];
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Wait for the low phase so a held trigger is never served twice.
          if (!sync2) begin
            readyOut <= 1'b0;
            state    <= IDLE;
          end
        end
        CLEAR: begin
`ifdef RAM_ZERO_INIT_EN
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: expectations are queued at request time and
// popped when readyOut rises. Zero-init checks are compiled in with RAM_ZERO_INIT_EN.
module tb_ram_responder;

  localparam int ADDR_BITS = 10;
  localparam int LATENCY   = 2;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataIn;
  logic [31:0] addrIn;
  logic        rwIn;
  logic        triggerIn;
  logic [31:0] dataOut;
  logic        readyOut;
  logic        errOut;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        rw;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  ram_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .dataIn    (dataIn),
    .addrIn    (addrIn),
    .rwIn      (rwIn),
    .triggerIn (triggerIn),
    .dataOut   (dataOut),
    .readyOut  (readyOut),
    .errOut    (errOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    foreach (model_mem[i]) model_mem[i] = 32'd0;
  endtask

  task automatic after_reset();
`ifdef RAM_ZERO_INIT_EN
    clear_model();
    repeat (DEPTH + 4) @(posedge clk);
`else
    repeat (2) @(posedge clk);
`endif
  endtask

  // Reference behaviour: misaligned or beyond the array -> error, zero data, no write.
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    logic bad;
    bad    = (addr[1:0] != 2'b00) || ((addr >> (ADDR_BITS + 2)) != 32'd0);
    e.rw   = rw;
    e.addr = addr;
    if (bad) begin
      e.data = 32'd0;
      e.err  = 1'b1;
    end else if (rw) begin
      model_mem[addr[ADDR_BITS+1:2]] = data;
      e.data = data;
      e.err  = 1'b0;
    end else begin
      e.data = model_mem[addr[ADDR_BITS+1:2]];
      e.err  = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    dataIn    = data;
    addrIn    = addr;
    rwIn      = rw;
    triggerIn = 1'b1;
  endtask

  // Edge count n starts at 1 for e0, the first edge sampling the trigger high,
  // so ready at e(LATENCY+2) shows up as n = LATENCY+3.
  task automatic finish_access(input int hold, input bit slow);
    exp_t        e;
    int          n;
    int          bound;
    int          drops;
    logic [31:0] held;
    bound = slow ? DEPTH + 100 : 40;
    n = 0;
    while (n < bound) begin
      @(posedge clk);
      #1;
      n++;
      if (readyOut) break;
    end
    if (slow) check("ready_after_clear", 32'(n > DEPTH), 32'd1);
    else      check("ready_latency", 32'(n), 32'(LATENCY + 3));
    e = sb.pop_front();
    check("read_data", dataOut, e.data);
    check("err_flag", 32'(errOut), 32'(e.err));
    $display("txn rw=%0d addr=0x%08h data=0x%08h err=%0d edges=%0d", e.rw, e.addr, dataOut, errOut, n);
    if (hold > 0) begin
      held  = dataOut;
      drops = 0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (readyOut !== 1'b1 || dataOut !== held) drops++;
      end
      check("hold_stable", 32'(drops), 32'd0);
    end
    @(negedge clk);
    triggerIn = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (!readyOut) break;
    end
    check("release_latency", 32'(n), 32'd3);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    triggerIn = 1'b0;
    rwIn      = 1'b0;
    addrIn    = 32'd0;
    dataIn    = 32'd0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(readyOut), 32'd0);
    check("reset_data", dataOut, 32'd0);
    check("reset_err", 32'(errOut), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    after_reset();

    issue(1'b1, 32'h10, 32'hDEADBEEF);      finish_access(0, 0);
    issue(1'b0, 32'h10, 32'h0);             finish_access(0, 0);
    issue(1'b0, 32'h13, 32'h0);             finish_access(0, 0);
    issue(1'b0, 32'h10, 32'h0);             finish_access(0, 0);
    issue(1'b1, 32'h0, 32'hCAFE0001);       finish_access(0, 0);
    issue(1'b1, 32'h00001000, 32'h1);       finish_access(0, 0);
    issue(1'b0, 32'h0, 32'h0);              finish_access(0, 0);
    issue(1'b0, 32'h80000000, 32'h0);       finish_access(0, 0);
    issue(1'b1, 32'hFFC, 32'h12345678);     finish_access(0, 0);
    issue(1'b0, 32'hFFC, 32'h0);            finish_access(0, 0);
    issue(1'b1, 32'h20, 32'h11);            finish_access(20, 0);
    issue(1'b0, 32'h20, 32'h0);             finish_access(0, 0);

    // Reset lands while the write to 0x20 is still counting down in BUSY.
    @(negedge clk);
    addrIn    = 32'h20;
    dataIn    = 32'h55;
    rwIn      = 1'b1;
    triggerIn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    triggerIn = 1'b0;
    @(posedge clk);
    #1;
    check("reset_in_busy_ready", 32'(readyOut), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    after_reset();
    issue(1'b0, 32'h20, 32'h0);             finish_access(0, 0);

`ifndef RAM_ZERO_INIT_EN
    // Trigger already high when reset releases counts as a fresh request.
    @(negedge clk);
    reset = 1'b1;
    issue(1'b0, 32'h10, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    finish_access(0, 0);
`else
    issue(1'b1, 32'h8, 32'hFF);             finish_access(0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    issue(1'b0, 32'h8, 32'h0);              finish_access(0, 1);
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
